gelu_lut_arbiter: RTL and testbench
===================================

# gelu_lut_arbiter

Round-robin arbiter that shares the single read port of the 96-entry GELU lookup ROM among `NUM_REQ` SFU lanes. Each lane issues a table index with a valid/ready handshake. The arbiter clamps out-of-range indices and drives the ROM address. It captures the ROM's registered output and returns the word to the originating lane through a per-lane response slot with valid/ready back-pressure. It sits between the SFU lane pipelines and the GELU ROM; the ROM write enable is held low.

## Interface
- `NUM_REQ`, 4, number of requesting lanes (2..8).
- `ADDR_WIDTH`, 7, ROM index width.
- `DATA_WIDTH`, 16, ROM word width.
- `LUT_DEPTH`, 96, number of valid ROM entries; indices `>= LUT_DEPTH` are clamped.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `req_valid`  in  NUM_REQ  lane i has an index to look up.
- `req_addr`  in  NUM_REQ*ADDR_WIDTH  lane i index in bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- `req_ready`  out  NUM_REQ  one-hot grant; the request is accepted when `req_valid[i] & req_ready[i]`.
- `rsp_valid`  out  NUM_REQ  response slot i holds a word.
- `rsp_data`  out  NUM_REQ*DATA_WIDTH  slot i word in bits [i*DATA_WIDTH +: DATA_WIDTH].
- `rsp_clamp`  out  NUM_REQ  slot i index was clamped.
- `rsp_ready`  in  NUM_REQ  lane i consumes its slot.
- `lut_addr`  out  ADDR_WIDTH  ROM read address.
- `lut_we`  out  1  ROM write enable; constant 0.
- `lut_q`  in  DATA_WIDTH  ROM registered read data, valid one cycle after the address.
- `busy`  out  1  a lookup is in flight or any slot is full.

## Operation
- Per-lane state: `inflight[i]` (pipeline stage 1 owns lane i) and `slot_full[i]`.
- Eligibility: lane i is eligible iff `req_valid[i] & ~inflight[i] & ~slot_full[i]`. A lane therefore has at most one outstanding lookup.
- Arbitration: a pointer `ptr` (reset 0) selects the first eligible lane scanning `ptr, ptr+1, ...` modulo NUM_REQ. On a grant to lane g, `ptr <= (g+1) mod NUM_REQ`. With no grant, `ptr` holds.
- `req_ready` is combinational from the current state and `req_valid`; at most one bit is high per cycle.
- Clamp: if the granted index is `>= LUT_DEPTH`, `lut_addr = LUT_DEPTH-1` and the clamp flag is 1. Otherwise `lut_addr` equals the index. With no grant, `lut_addr = 0`.
- Stage 1 register, loaded on a grant: `s1_valid`, `s1_id`, `s1_clamp`. Set `inflight[g]` and clear it when stage 1 retires.
- Stage 2 (retire): when `s1_valid`, write `lut_q` into slot `s1_id` with its clamp flag, and set `slot_full`.
- Slot drain: `rsp_valid[i] & rsp_ready[i]` clears `slot_full[i]` at the edge. `rsp_data[i]` and `rsp_clamp[i]` stay stable while `rsp_valid[i]` is high.
- A slot is never written while full. This is guaranteed by the eligibility rule; the bench asserts it.
- `rsp_ready` with `rsp_valid` low is ignored.
- `busy = s1_valid | (|slot_full)`.

## Timing
- Reset values (async, immediate): `req_ready` 0, `rsp_valid` 0, `rsp_data` 0, `rsp_clamp` 0, `lut_addr` 0, `lut_we` 0, `busy` 0, `ptr` 0. All inflight state is cleared.
- Latency: request accepted at the end of cycle T; ROM samples `lut_addr` at that edge; `lut_q` is valid in T+1; slot written at end of T+1; `rsp_valid` high in T+2.
- Throughput: one grant per cycle across different lanes.
- A single lane with `rsp_ready` tied high repeats every 3 cycles (grant T, inflight T+1, slot T+2, eligible again T+3).
- A lane whose slot drains in cycle C becomes eligible in C+1, not in C.
- Reset mid-operation: in-flight lookups and full slots are discarded; no response is emitted after reset deasserts. The first grant can occur in the first cycle after release.
- `req_valid` deasserting without a handshake is legal and drops the request with no side effect.

## Test plan
- Lane 0 requests index 0, `rsp_ready` high -> `req_ready[0]` high in T; `rsp_valid[0]` in T+2 with data 0x0330 and clamp 0; `lut_addr` is 0 in T.
- Lane 2 requests index 100 -> `lut_addr` 95; `rsp_data[2]` 0x7FFD with `rsp_clamp[2]` 1. Index 95 gives the same data with clamp 0.
- All 4 lanes request indices 1, 2, 3, 4 in the same cycle -> grants to lanes 0, 1, 2, 3 on consecutive cycles; responses 0x0661, 0x098F, 0x0CBB, 0x0FE4, each 2 cycles after its grant.
- Lanes 0 and 1 held valid continuously with `rsp_ready` high -> grants alternate starting at lane 0, with no lane starved. Each lane is also limited by the 3-cycle per-lane rate.
- Lane 0 `rsp_ready` low for 5 cycles after a response with index 47 -> `rsp_data[0]` holds 0x6EE5; lane 0 is not regranted while lanes 1..3 continue to be served. Lane 0 is regranted the cycle after the drain.
- `rst` asserted the cycle after a grant -> all outputs go to 0 immediately; no `rsp_valid` pulse appears after release; `ptr` restarts at lane 0.

Source files
------------

// File: rtl/gelu_lut_arbiter.sv
// gelu_lut_arbiter: round-robin sharing of the GELU ROM read port among SFU lanes,
// with index clamping and a per-lane response slot under valid/ready back-pressure.
module gelu_lut_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 16,
  parameter int LUT_DEPTH  = 96
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
  output logic [NUM_REQ-1:0]               req_ready,
  output logic [NUM_REQ-1:0]               rsp_valid,
  output logic [NUM_REQ*DATA_WIDTH-1:0]    rsp_data,
  output logic [NUM_REQ-1:0]               rsp_clamp,
  input  logic [NUM_REQ-1:0]               rsp_ready,
  output logic [ADDR_WIDTH-1:0]            lut_addr,
  output logic                             lut_we,
  input  logic [DATA_WIDTH-1:0]            lut_q,
  output logic                             busy
);
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(LUT_DEPTH - 1);
  logic [PW-1:0] ptr, gid, scan, s1_id;
  logic s1_valid, s1_clamp, found, clamp;
  logic [NUM_REQ-1:0] inflight, slot_full, slot_clamp, elig, gnt;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] slot_data;
  logic [ADDR_WIDTH-1:0] gaddr;
  // Outputs read as idle while reset is held, even if lanes are requesting.
  assign inflight = s1_valid ? (NUM_REQ'(1) << s1_id) : '0;
  assign elig = req_valid & ~inflight & ~slot_full & {NUM_REQ{~rst}};
  always_comb begin
    gnt = '0;
    gid = '0;
    scan = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan = PW'((int'(ptr) + k) % NUM_REQ);
      if (!found && elig[scan]) begin
        found = 1'b1;
        gid = scan;
        gnt[scan] = 1'b1;
      end
    end
  end
  assign gaddr = req_addr[gid*ADDR_WIDTH +: ADDR_WIDTH];
  assign clamp = found && (gaddr > LAST);
  assign lut_addr = !found ? '0 : clamp ? LAST : gaddr;
  assign req_ready = gnt;
  assign lut_we = 1'b0;
  assign busy = s1_valid | (|slot_full);
  assign rsp_valid = slot_full;
  assign rsp_clamp = slot_clamp;
  assign rsp_data = slot_data;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
      s1_valid <= 1'b0;
      s1_id <= '0;
      s1_clamp <= 1'b0;
    end else begin
      s1_valid <= found;
      if (found) begin
        s1_id <= gid;
        s1_clamp <= clamp;
        ptr <= (gid == PW'(NUM_REQ - 1)) ? '0 : gid + 1'b1;
      end
    end
  end
  // A lane in stage 1 always has an empty slot, so retire and drain never collide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_full <= '0;
      slot_data <= '0;
      slot_clamp <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (s1_valid && s1_id == PW'(i)) begin
          slot_full[i] <= 1'b1;
          slot_data[i] <= lut_q;
          slot_clamp[i] <= s1_clamp;
        end else if (rsp_ready[i]) begin
          slot_full[i] <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_gelu_lut_arbiter.sv
// tb_gelu_lut_arbiter: directed and random traffic checked against a timestamp-based
// model of grants and responses, with a registered ROM model driving lut_q.
module tb_gelu_lut_arbiter;
  localparam int N = 4;
  logic clk = 1'b0, rst = 1'b1;
  logic [N-1:0] req_valid = '0, req_ready, rsp_valid, rsp_clamp, rsp_ready = '1;
  logic [N*7-1:0] req_addr = '0;
  logic [N*16-1:0] rsp_data;
  logic [6:0] lut_addr;
  logic lut_we, busy;
  logic [15:0] lut_q = '0;
  int tests = 0, fails = 0, cyc = 0, mptr = 0;
  bit one_shot = 1'b0;
  bit mbusy [N];
  int mat [N];
  logic [15:0] mdata [N];
  bit mclamp [N];

  gelu_lut_arbiter dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rsp_clamp(rsp_clamp), .rsp_ready(rsp_ready), .lut_addr(lut_addr),
    .lut_we(lut_we), .lut_q(lut_q), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] rom(input logic [6:0] a);
    case (a)
      7'd0:  rom = 16'h0330;
      7'd1:  rom = 16'h0661;
      7'd2:  rom = 16'h098F;
      7'd3:  rom = 16'h0CBB;
      7'd4:  rom = 16'h0FE4;
      7'd47: rom = 16'h6EE5;
      7'd95: rom = 16'h7FFD;
      default: rom = {1'b1, a, 8'h5A};
    endcase
  endfunction

  always @(posedge clk) lut_q <= rom(lut_addr);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_addr(input int lane, input int a);
    req_addr[lane*7 +: 7] = 7'(a);
  endtask

  // Inputs are applied at a negedge; sample #1 later, then advance the model to the next edge.
  task automatic tick();
    int g;
    logic [N-1:0] er, ev;
    logic [6:0] ra, ea;
    #1;
    g = -1;
    for (int k = 0; k < N; k++) begin
      int j;
      j = (mptr + k) % N;
      if (g < 0 && req_valid[j] && !mbusy[j]) g = j;
    end
    er = '0;
    ea = '0;
    ra = '0;
    if (g >= 0) begin
      er[g] = 1'b1;
      ra = req_addr[g*7 +: 7];
      ea = (ra >= 7'd96) ? 7'd95 : ra;
    end
    for (int i = 0; i < N; i++) ev[i] = mbusy[i] && cyc >= mat[i];
    chk($sformatf("req_ready c%0d", cyc), 64'(req_ready), 64'(er));
    chk($sformatf("lut_addr c%0d", cyc), 64'(lut_addr), 64'(ea));
    chk($sformatf("rsp_valid c%0d", cyc), 64'(rsp_valid), 64'(ev));
    chk($sformatf("busy c%0d", cyc), 64'(busy), 64'(mbusy.or() != 0));
    for (int i = 0; i < N; i++)
      if (ev[i]) begin
        chk($sformatf("rsp_data%0d c%0d", i, cyc), 64'(rsp_data[i*16 +: 16]), 64'(mdata[i]));
        chk($sformatf("rsp_clamp%0d c%0d", i, cyc), 64'(rsp_clamp[i]), 64'(mclamp[i]));
      end
    for (int i = 0; i < N; i++) if (ev[i] && rsp_ready[i]) mbusy[i] = 1'b0;
    if (g >= 0) begin
      mbusy[g] = 1'b1;
      mat[g] = cyc + 2;
      mdata[g] = rom(ea);
      mclamp[g] = (ra >= 7'd96);
      mptr = (g + 1) % N;
    end
    cyc++;
    @(negedge clk);
    if (one_shot) req_valid = req_valid & ~er;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '1;
    #1;
    chk("rst req_ready", 64'(req_ready), 64'd0);
    chk("rst rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst rsp_data", rsp_data, 64'd0);
    chk("rst rsp_clamp", 64'(rsp_clamp), 64'd0);
    chk("rst lut_addr", 64'(lut_addr), 64'd0);
    chk("rst lut_we", 64'(lut_we), 64'd0);
    chk("rst busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    req_valid = '0;
    for (int i = 0; i < N; i++) mbusy[i] = 1'b0;
    mptr = 0;
    cyc = 0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    do_reset();
    one_shot = 1'b1;
    // single lookup, index 0
    req_valid = 4'b0001; set_addr(0, 0);
    repeat (4) tick();
    // clamped and in-range top entry
    req_valid = 4'b0100; set_addr(2, 100);
    repeat (4) tick();
    req_valid = 4'b0100; set_addr(2, 95);
    repeat (4) tick();
    // all lanes at once
    for (int i = 0; i < N; i++) set_addr(i, i + 1);
    req_valid = 4'b1111;
    repeat (7) tick();
    // two lanes held continuously
    one_shot = 1'b0;
    set_addr(0, 10); set_addr(1, 20);
    req_valid = 4'b0011;
    repeat (12) tick();
    req_valid = '0;
    repeat (3) tick();
    // lane 0 back-pressured while others are served
    one_shot = 1'b1;
    set_addr(0, 47); req_valid = 4'b0001; rsp_ready = 4'b1110;
    repeat (3) tick();
    one_shot = 1'b0;
    set_addr(1, 5); set_addr(2, 60); set_addr(3, 127);
    req_valid = 4'b1111;
    repeat (5) tick();
    rsp_ready = '1;
    repeat (6) tick();
    req_valid = '0;
    repeat (3) tick();
    // reset the cycle after a grant
    one_shot = 1'b1;
    set_addr(1, 33); req_valid = 4'b0010;
    tick();
    do_reset();
    repeat (4) tick();
    set_addr(0, 7); set_addr(1, 8); set_addr(2, 9); set_addr(3, 11);
    req_valid = 4'b1111;
    repeat (7) tick();
    // random traffic
    one_shot = 1'b0;
    for (int n = 0; n < 400; n++) begin
      req_valid = 4'($urandom);
      for (int i = 0; i < N; i++) begin
        set_addr(i, int'($urandom_range(0, 127)));
        rsp_ready[i] = ($urandom_range(0, 3) != 0);
      end
      tick();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
